// File: rtl/f32mul_rr_sched.sv
// Purpose: round-robin share of one f32 multiplier among NUM_REQ valid/ready requesters.
// Latency: exactly LAT cycles from operand accept to rsp_valid (issue stage + LAT-2 product regs).
// Backpressure: one op outstanding per requester; a held result blocks only its own requester.
module f32mul_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int LAT     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_x,
    input  logic [32*NUM_REQ-1:0]   req_y,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [32*NUM_REQ-1:0]   rsp_data,
    output logic                    busy,
    output logic [31:0]             op_count
);

    localparam int PW = $clog2(NUM_REQ);

    // Single-precision multiply: round to nearest even, subnormals flushed to
    // zero on both sides (rounding happens first), canonical positive NaN.
    function automatic logic [31:0] f32_mul(input logic [31:0] a, input logic [31:0] b);
        logic              s, za, zb, ia, ib, na, nb, g, st, up;
        logic [7:0]        ea, eb;
        logic [23:0]       ma, mb, mant;
        logic [47:0]       p;
        logic [24:0]       mr;
        logic signed [9:0] e;
        logic [31:0]       r;
        s  = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        za = (ea == 8'h00);
        zb = (eb == 8'h00);
        ia = (ea == 8'hFF) && (a[22:0] == 23'd0);
        ib = (eb == 8'hFF) && (b[22:0] == 23'd0);
        na = (ea == 8'hFF) && (a[22:0] != 23'd0);
        nb = (eb == 8'hFF) && (b[22:0] != 23'd0);
        ma = {1'b1, a[22:0]};
        mb = {1'b1, b[22:0]};
        p  = ma * mb;
        if (p[47]) begin
            mant = p[47:24];
            g    = p[23];
            st   = |p[22:0];
            e    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd126;
        end else begin
            mant = p[46:23];
            g    = p[22];
            st   = |p[21:0];
            e    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        end
        up = g & (st | mant[0]);
        mr = {1'b0, mant} + {24'd0, up};
        // carry out of rounding leaves fraction bits all zero, only the exponent moves
        if (mr[24]) begin
            e = e + 10'sd1;
        end
        if (na || nb || (ia && zb) || (za && ib)) begin
            r = 32'h7FC0_0000;
        end else if (ia || ib) begin
            r = {s, 8'hFF, 23'd0};
        end else if (za || zb) begin
            r = {s, 31'd0};
        end else if (e >= 10'sd255) begin
            r = {s, 8'hFF, 23'd0};
        end else if (e <= 10'sd0) begin
            r = {s, 31'd0};
        end else begin
            r = {s, e[7:0], mr[22:0]};
        end
        return r;
    endfunction

    logic [NUM_REQ-1:0] pend_q, pend_d, rsp_vld_q, rsp_vld_d, elig, gnt_oh, hs;
    logic [PW-1:0]      ptr_q, ptr_d, gnt_idx, iss_tag_q, ex_tag;
    logic [PW:0]        sum;
    logic               gnt_any, accept, iss_vld_q, ex_vld;
    logic [31:0]        iss_x_q, iss_y_q, core_p, ex_dat, op_count_q, op_count_d;
    logic [31:0]        rbuf_q [NUM_REQ];

    assign elig       = req_valid & ~pend_q;
    assign accept     = gnt_any & ~rst;
    assign req_ready  = rst ? '0 : gnt_oh;
    assign hs         = rsp_vld_q & rsp_ready;
    assign op_count_d = op_count_q + {31'd0, accept};
    assign core_p     = f32_mul(iss_x_q, iss_y_q);

    // Grant: first eligible requester at or above ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        sum     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_REQ)) begin
                sum = sum - (PW+1)'(NUM_REQ);
            end
            if (!gnt_any && elig[sum[PW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = sum[PW-1:0];
            end
        end
        if (gnt_any) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    // Next state of pending flags, held-result flags and the rotation pointer.
    always_comb begin
        pend_d    = pend_q & ~hs;
        rsp_vld_d = rsp_vld_q & ~hs;
        ptr_d     = ptr_q;
        if (accept) begin
            pend_d[gnt_idx] = 1'b1;
            ptr_d = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
        if (ex_vld) begin
            rsp_vld_d[ex_tag] = 1'b1;
        end
    end

    // Product pipe between the core and the result buffers; absent when LAT is 2.
    if (LAT == 2) begin : g_nopipe
        assign ex_vld = iss_vld_q;
        assign ex_dat = core_p;
        assign ex_tag = iss_tag_q;
    end else begin : g_pipe
        logic [LAT-3:0] pv_q;
        logic [31:0]    pd_q [LAT-2];
        logic [PW-1:0]  pt_q [LAT-2];
        // Valid bits shift every cycle; no stall is ever needed.
        always_ff @(posedge clk) begin
            if (rst) begin
                pv_q <= '0;
            end else begin
                pv_q[0] <= iss_vld_q;
                pd_q[0] <= core_p;
                pt_q[0] <= iss_tag_q;
                for (int k = 1; k < LAT - 2; k++) begin
                    pv_q[k] <= pv_q[k-1];
                    pd_q[k] <= pd_q[k-1];
                    pt_q[k] <= pt_q[k-1];
                end
            end
        end
        assign ex_vld = pv_q[LAT-3];
        assign ex_dat = pd_q[LAT-3];
        assign ex_tag = pt_q[LAT-3];
    end

    // Scheduler state, issue stage and per-requester result buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            rsp_vld_q  <= '0;
            ptr_q      <= '0;
            op_count_q <= '0;
            iss_vld_q  <= 1'b0;
            iss_x_q    <= '0;
            iss_y_q    <= '0;
            iss_tag_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                rbuf_q[i] <= '0;
            end
        end else begin
            pend_q     <= pend_d;
            rsp_vld_q  <= rsp_vld_d;
            ptr_q      <= ptr_d;
            op_count_q <= op_count_d;
            iss_vld_q  <= accept;
            if (accept) begin
                iss_x_q   <= req_x[32*gnt_idx +: 32];
                iss_y_q   <= req_y[32*gnt_idx +: 32];
                iss_tag_q <= gnt_idx;
            end
            if (ex_vld) begin
                rbuf_q[ex_tag] <= ex_dat;
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_out
        assign rsp_data[32*i +: 32] = rbuf_q[i];
    end

    assign rsp_valid = rsp_vld_q;
    assign busy      = |pend_q;
    assign op_count  = op_count_q;

endmodule
